// File: rtl/result_triple_capture.sv
// result_triple_capture
//   Watches a 32-bit result triple (in1/in2/in3) from an FSM-driven test
//   module. It records every distinct triple in a small FIFO, counts changes,
//   and flags when the most recently captured triple equals exp1..exp3.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     in1..in3 are meaningful this cycle
//   in1..in3     result triple under observation
//   exp1..exp3   expected triple for the match flag
//   rd_en        pop request
//   rd_valid     one-cycle pulse: rd_data1..3 hold a popped entry
//   rd_data1..3  popped triple (holds when rd_valid=0)
//   empty/full   FIFO occupancy flags
//   overflow     sticky: a change was dropped because the FIFO was full
//   match        last captured triple equals exp1..exp3 at capture time
//   change_count saturating count of detected changes
module result_triple_capture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] exp1,
  input  logic [WIDTH-1:0] exp2,
  input  logic [WIDTH-1:0] exp3,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic [WIDTH-1:0] rd_data3,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             match,
  output logic [CNT_W-1:0] change_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {NO_HIST, TRACKING} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_change;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;

  logic [WIDTH-1:0]   r_last1, r_last2, r_last3;
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [3*WIDTH-1:0] r_mem [DEPTH];
  logic               r_rd_valid;
  logic [WIDTH-1:0]   r_rd1, r_rd2, r_rd3;
  logic               r_overflow;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;

  // Tracker FSM: the first valid triple after reset has nothing to compare
  // against, so it always counts as a change.
  always_comb begin
    w_state_next = r_state;
    w_change     = 1'b0;
    case (r_state)
      NO_HIST: begin
        if (in_valid) begin
          w_change     = 1'b1;
          w_state_next = TRACKING;
        end
      end
      TRACKING: begin
        if (in_valid && ({in1, in2, in3} != {r_last1, r_last2, r_last3}))
          w_change = 1'b1;
      end
      default: w_state_next = NO_HIST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= NO_HIST;
    else        r_state <= w_state_next;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop on an empty FIFO is ignored (no bypass); a push into a full FIFO
  // is still accepted when a pop frees the slot on the same edge.
  assign w_pop  = rd_en && !w_empty;
  assign w_push = w_change && (!w_full || w_pop);

  // Storage has no reset so it can map onto RAM; only pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {in1, in2, in3};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_rd3      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        {r_rd1, r_rd2, r_rd3} <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_change && !w_push) r_overflow <= 1'b1;
    end
  end

  // Capture side: updates on every change, whether or not the push was dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last1 <= '0;
      r_last2 <= '0;
      r_last3 <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else if (w_change) begin
      r_last1 <= in1;
      r_last2 <= in2;
      r_last3 <= in3;
      r_match <= (in1 == exp1) && (in2 == exp2) && (in3 == exp3);
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_data1     = r_rd1;
  assign rd_data2     = r_rd2;
  assign rd_data3     = r_rd3;
  assign empty        = w_empty;
  assign full         = w_full;
  assign overflow     = r_overflow;
  assign match        = r_match;
  assign change_count = r_count;

endmodule

// File: tb/tb_result_triple_capture.sv
// Testbench for result_triple_capture: directed stimulus; expected pops go
// into a queue that an independent monitor drains whenever rd_valid is seen.
module tb_result_triple_capture;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in1, in2, in3;
  logic [WIDTH-1:0] exp1, exp2, exp3;
  logic             rd_en;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data1, rd_data2, rd_data3;
  logic             empty, full, overflow, match;
  logic [CNT_W-1:0] change_count;

  int errors = 0;
  int checks = 0;

  logic [3*WIDTH-1:0] exp_q[$];

  result_triple_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3),
    .exp1(exp1), .exp2(exp2), .exp3(exp3),
    .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .empty(empty), .full(full), .overflow(overflow), .match(match),
    .change_count(change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got (%0h,%0h,%0h) expected no pop", rd_data1, rd_data2, rd_data3);
      end else begin
        logic [3*WIDTH-1:0] e;
        e = exp_q.pop_front();
        if ({rd_data1, rd_data2, rd_data3} !== e) begin
          errors++;
          $display("FAIL pop_data: got (%0h,%0h,%0h) expected (%0h,%0h,%0h)",
                   rd_data1, rd_data2, rd_data3,
                   e[3*WIDTH-1:2*WIDTH], e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end else begin
          $display("ok   pop_data: (%0h,%0h,%0h)", rd_data1, rd_data2, rd_data3);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_triple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c);
    in1 = a; in2 = b; in3 = c;
  endtask

  // Issue one pop and queue the hand-computed entry it must return.
  task automatic pop_expect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c);
    exp_q.push_back({a, b, c});
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    set_triple(0, 0, 0);
    exp1 = 2; exp2 = 5; exp3 = 7;
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_match", match, 0);
    chk("rst_count", change_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data1", rd_data1, 0);

    // First triple held for three cycles: one change only.
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    set_triple(32'hA, 32'h14, 32'h1E);
    repeat (3) step();
    chk("first_count", change_count, 1);
    chk("first_empty", empty, 0);
    chk("first_match", match, 0);

    set_triple(2, 5, 7);
    step();
    chk("second_count", change_count, 2);
    chk("second_match", match, 1);

    pop_expect(32'hA, 32'h14, 32'h1E);
    pop_expect(2, 5, 7);
    chk("drained_empty", empty, 1);

    // Pop on empty: ignored, data holds.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    @(negedge clk);
    chk("empty_pop_valid", rd_valid, 0);
    chk("empty_pop_hold", {rd_data1, rd_data3}, {32'd2, 32'd7});

    // in_valid low with a new triple: no change; exp change: match holds.
    in_valid = 1'b0;
    set_triple(3, 3, 3);
    exp1 = 3; exp2 = 3; exp3 = 3;
    step();
    chk("invalid_count", change_count, 2);
    chk("match_hold", match, 1);
    exp1 = 2; exp2 = 5; exp3 = 7;

    // Fill and overflow from a fresh reset.
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_triple(i, 0, 0);
      step();
    end
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", change_count, 5);
    chk("ovf_match", match, 0);

    // Full with simultaneous pop and push.
    set_triple(6, 0, 0);
    pop_expect(1, 0, 0);
    chk("pushpop_full", full, 1);
    chk("pushpop_count", change_count, 6);
    chk("pushpop_overflow", overflow, 1);
    pop_expect(2, 0, 0);
    pop_expect(3, 0, 0);
    pop_expect(4, 0, 0);
    pop_expect(6, 0, 0);
    chk("pushpop_empty", empty, 1);

    // Three entries, then asynchronous reset without a clock edge.
    for (int i = 7; i <= 9; i++) begin
      set_triple(i, 0, 0);
      step();
    end
    chk("three_count", change_count, 9);
    chk("three_empty", empty, 0);
    chk("three_full", full, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_empty", empty, 1);
    chk("async_count", change_count, 0);
    chk("async_overflow", overflow, 0);
    chk("async_rd_data1", rd_data1, 0);

    @(negedge clk);
    reset = 1'b1;
    set_triple(2, 5, 7);
    step();
    chk("post_rst_count", change_count, 1);
    chk("post_rst_match", match, 1);
    chk("post_rst_empty", empty, 0);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_triple_capture.md
Name: result_triple_capture

Overview:
- Downstream consumer of the FSM-generated test modules, which drive three 32-bit result words (out1/out2/out3) that change at state transitions.
- Samples the result triple every valid cycle and detects changes against the last captured triple.
- Queues each distinct triple in a small FIFO for the bench to read back, and flags when the latest captured triple equals an expected triple.
- Replaces print-based `$monitor` inspection with a checkable, cycle-accurate record.

Parameters:
- WIDTH, 32, width of each result word.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CNT_W, 16, width of change counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- in_valid  input  1  result triple on in1..in3 is meaningful this cycle.
- in1  input  WIDTH  result word 1 (from out1).
- in2  input  WIDTH  result word 2 (from out2).
- in3  input  WIDTH  result word 3 (from out3).
- exp1  input  WIDTH  expected word 1.
- exp2  input  WIDTH  expected word 2.
- exp3  input  WIDTH  expected word 3.
- rd_en  input  1  pop request.
- rd_valid  output  1  rd_data1..3 hold a popped entry this cycle (1-cycle pulse).
- rd_data1  output  WIDTH  popped word 1.
- rd_data2  output  WIDTH  popped word 2.
- rd_data3  output  WIDTH  popped word 3.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky: a change was dropped because the FIFO was full.
- match  output  1  last captured triple equals exp1..exp3.
- change_count  output  CNT_W  number of detected changes since reset.

Behaviour:
- Reset (reset==0, asynchronous, immediate):
  - rd_valid=0, rd_data*=0, empty=1, full=0, overflow=0, match=0, change_count=0.
  - FIFO pointers=0; tracker state=NO_HIST; last-captured triple registers=0.
- Tracker FSM:
  - NO_HIST: first cycle with in_valid=1 is a change; go to TRACKING.
  - TRACKING: in_valid=1 and {in1,in2,in3} differs from the last captured triple in any bit → change; stay in TRACKING.
  - in_valid=0 or an identical triple → no change, no state update.
- On a change, at that rising edge:
  - Last-captured triple ← inputs.
  - change_count += 1, saturating at all-ones.
  - Push attempted.
  - match ← (in1==exp1 && in2==exp2 && in3==exp3), evaluated on the incoming triple.
- match changes only on a change event. It holds between changes, even if exp* changes.
- Push:
  - Accepted if not full, or if full and a pop occurs the same cycle.
  - Otherwise dropped; overflow←1 (sticky until reset). change_count and the last-captured triple still update on a drop.
- Pop:
  - rd_en=1 and empty=0 → oldest entry registered onto rd_data1..3 and rd_valid=1 the next cycle.
  - rd_en with empty=1 → ignored; rd_valid=0; rd_data* hold.
  - rd_data* hold their value when rd_valid=0.
- Simultaneous push+pop when empty: no bypass. Pop is ignored, push is stored, empty=0 after the edge.
- Simultaneous push+pop when partially full: occupancy unchanged, pointers both advance.
- Pointers: log2(DEPTH)+1 bits. Wrap is silent; full/empty are derived from the extra MSB.
- Latency: empty/full/match/change_count reflect a change one edge after in_valid is sampled. Read latency is 1 cycle.
- Reset mid-operation: all state clears immediately. The first valid triple after release is again a change, even if it equals the pre-reset value.

Test Plan:
- Reset low → all outputs 0 except empty=1.
- Release reset; in_valid=1, triple (0xA,0x14,0x1E) for 3 cycles, exp=(2,5,7) → change_count=1, one entry, match=0, empty=0.
- Triple → (2,5,7) → change_count=2, match=1. Pop twice → rd_valid pulses; data (0xA,0x14,0x1E) then (2,5,7); empty=1.
- Push 4 distinct triples (1,0,0)..(4,0,0), then (5,0,0) → full=1, overflow=1, change_count=5. Pops return 1..4 only.
- Full, then rd_en=1 and a new triple (6,0,0) in the same cycle → full stays 1, rd_data=(1,0,0), later pops return 2,3,4,6.
- Drive reset low mid-FIFO with count=3 → outputs clear without a clock edge. After release, triple (2,5,7) again → change_count=1.
